// File: rtl/geo_pkg.sv
// Shared types and default constants for the store-capture path.
package geo_pkg;

  typedef enum logic [1:0] {
    RUN,
    FLUSH,
    FINISHED
  } capture_state_t;

  localparam int          CAP_DEPTH     = 16;
  localparam logic [31:0] CAP_ADDR_LO   = 32'h0000_0400;
  localparam logic [31:0] CAP_ADDR_HI   = 32'h0000_FFFC;
  localparam logic [31:0] CAP_DONE_ADDR = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } store_entry_t;

  // Word-aligned address inside the inclusive [lo, hi] window.
  function automatic logic in_window(input logic [31:0] adr,
                                     input logic [31:0] lo,
                                     input logic [31:0] hi);
    return (adr >= lo) && (adr <= hi) && (adr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/store_capture_fifo_sync_fifo.sv
// Synchronous FIFO with occupancy count; a push into a full FIFO is taken when a pop happens at the same edge.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Head reads zero while empty so stale storage never leaks to the consumer.
  assign dout = empty ? '0 : mem[rd_ptr];

  // NOTE: storage is deliberately not reset; only pointers and count are, which is what makes contents "discarded".
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/store_capture_fifo.sv
// Snoops core stores, buffers in-window ones for a valid/ready consumer, and flushes to done on a sentinel store.
module store_capture_fifo
  import geo_pkg::*;
#(
  parameter int          DEPTH     = CAP_DEPTH,
  parameter logic [31:0] ADDR_LO   = CAP_ADDR_LO,
  parameter logic [31:0] ADDR_HI   = CAP_ADDR_HI,
  parameter logic [31:0] DONE_ADDR = CAP_DONE_ADDR
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   MemWrite,
  input  logic [31:0]            DataAdr,
  input  logic [31:0]            WriteData,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_addr,
  output logic [31:0]            out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty,
  output logic                   overflow,
  output logic [15:0]            drop_count,
  output logic [31:0]            store_count,
  output logic                   done
);

  localparam int CW = $clog2(DEPTH) + 1;

  capture_state_t state;
  capture_state_t state_next;
  store_entry_t   din;
  store_entry_t   dout;
  logic           is_sentinel;
  logic           is_capture;
  logic           pop;
  logic           push;
  logic           drop;

  assign is_sentinel = MemWrite && (DataAdr == DONE_ADDR);
  assign is_capture  = MemWrite && !is_sentinel && in_window(DataAdr, ADDR_LO, ADDR_HI);

  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign din       = '{addr: DataAdr, data: WriteData};
  assign out_addr  = dout.addr;
  assign out_data  = dout.data;

  sync_fifo #(
    .WIDTH ($bits(store_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    push       = 1'b0;
    drop       = 1'b0;
    unique case (state)
      RUN: begin
        if (is_sentinel) begin
          state_next = FLUSH;
        end else if (is_capture) begin
          if (!full || pop) push = 1'b1;
          else              drop = 1'b1;
        end
      end
      // Nothing is pushed in FLUSH, so occupancy only falls; finish on the edge it reaches zero.
      FLUSH: begin
        if (count == '0 || (pop && count == CW'(1))) state_next = FINISHED;
      end
      FINISHED: state_next = FINISHED;
      default:  state_next = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      done        <= 1'b0;
      overflow    <= 1'b0;
      drop_count  <= '0;
      store_count <= '0;
    end else begin
      state <= state_next;
      done  <= (state_next == FINISHED);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      end
      if (push) store_count <= store_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_store_capture_fifo.sv
// Scoreboard bench for store_capture_fifo: a behavioural model predicts pushes, drops and state; popped heads are compared in order.
module tb_store_capture_fifo;
  import geo_pkg::*;

  localparam int DEPTH = 16;
  localparam logic [31:0] DONE = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite = 1'b0;
  logic [31:0] DataAdr = '0;
  logic [31:0] WriteData = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [4:0]  count;
  logic        full;
  logic        empty;
  logic        overflow;
  logic [15:0] drop_count;
  logic [31:0] store_count;
  logic        done;

  store_capture_fifo dut (
    .clk         (clk),
    .reset       (reset),
    .MemWrite    (MemWrite),
    .DataAdr     (DataAdr),
    .WriteData   (WriteData),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_addr    (out_addr),
    .out_data    (out_data),
    .count       (count),
    .full        (full),
    .empty       (empty),
    .overflow    (overflow),
    .drop_count  (drop_count),
    .store_count (store_count),
    .done        (done)
  );

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  store_entry_t   sb[$];
  int             m_count;
  capture_state_t m_state;
  logic           m_overflow;
  int             m_drop;
  int             m_store;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else pass_cnt++;
  endtask

  // One clock: predict this edge from the model, compare any popped head, then advance.
  task automatic cycle();
    logic pop, sent, inwin;
    store_entry_t exp;
    if (reset) begin
      @(posedge clk); #1;
      sb.delete();
      m_count = 0; m_state = RUN; m_overflow = 1'b0; m_drop = 0; m_store = 0;
      return;
    end
    pop   = (m_count != 0) && out_ready;
    sent  = MemWrite && (DataAdr == DONE);
    inwin = MemWrite && !sent && DataAdr >= 32'h400 && DataAdr <= 32'hFFFC && DataAdr[1:0] == 2'b00;
    if (pop) begin
      if (sb.size() == 0) check("sb_underflow", 64'd1, 64'd0);
      else begin
        exp = sb.pop_front();
        check("pop_entry", {out_addr, out_data}, exp);
      end
    end
    case (m_state)
      RUN: begin
        if (sent) m_state = FLUSH;
        else if (inwin) begin
          if (m_count < DEPTH || pop) begin
            sb.push_back('{addr: DataAdr, data: WriteData});
            m_store++;
            m_count++;
          end else begin
            m_overflow = 1'b1;
            if (m_drop < 16'hFFFF) m_drop++;
          end
        end
      end
      FLUSH: if (m_count - int'(pop) == 0) m_state = FINISHED;
      default: ;
    endcase
    if (pop) m_count--;
    @(posedge clk); #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    MemWrite = 1'b1; DataAdr = a; WriteData = d;
    cycle();
    MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"},    count,       m_count);
    check({tag, "_full"},     full,        m_count == DEPTH);
    check({tag, "_empty"},    empty,       m_count == 0);
    check({tag, "_valid"},    out_valid,   m_count != 0);
    check({tag, "_overflow"}, overflow,    m_overflow);
    check({tag, "_drops"},    drop_count,  m_drop);
    check({tag, "_stores"},   store_count, m_store);
    check({tag, "_done"},     done,        m_state == FINISHED);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    do_reset();
    check_state("reset");
    check("reset_head", {out_addr, out_data}, 64'd0);

    // Basic capture plus window boundaries.
    out_ready = 1'b1;
    store(32'h400, 32'hA);
    check("basic_head0", {out_addr, out_data}, {32'h400, 32'hA});
    store(32'h404, 32'hB);
    check("basic_head1", {out_addr, out_data}, {32'h404, 32'hB});
    store(32'h10, 32'hC);
    idle(2);
    check("basic_stores", store_count, 32'd2);
    check_state("basic");
    store(32'h3FC, 32'h1);
    store(32'h402, 32'h2);
    store(32'h1_0000, 32'h3);
    store(32'hFFFC, 32'hD);
    idle(2);
    check_state("bounds");
    check("bounds_stores", store_count, 32'd3);

    // Overflow: 18 stores into 16 slots, then drain.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 18; i++) store(32'h400 + 32'(4 * i), 32'(100 + i));
    check("ovf_full", full, 1'b1);
    check("ovf_count", count, 5'd16);
    check("ovf_flag", overflow, 1'b1);
    check("ovf_drops", drop_count, 16'd2);
    check_state("ovf");
    out_ready = 1'b1;
    idle(18);
    check_state("ovf_drain");
    check("ovf_sb_left", sb.size(), 0);

    // Full with a same-edge pop: the push is taken.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) store(32'h800 + 32'(4 * i), 32'(200 + i));
    out_ready = 1'b1;
    store(32'h900, 32'hBEEF);
    out_ready = 1'b0;
    check("fullpop_count", count, 5'd16);
    check("fullpop_drops", drop_count, 16'd0);
    check_state("fullpop");
    out_ready = 1'b1;
    idle(DEPTH + 2);
    check("fullpop_sb_left", sb.size(), 0);

    // Sentinel with three queued entries, then a store that must be ignored.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) store(32'hA00 + 32'(4 * i), 32'(300 + i));
    store(DONE, 32'h0);
    store(32'h500, 32'h77);
    check("flush_count", count, 5'd3);
    check("flush_done0", done, 1'b0);
    check_state("flush");
    out_ready = 1'b1;
    idle(2);
    check("flush_done_early", done, 1'b0);
    idle(1);
    check("flush_done", done, 1'b1);
    check("flush_empty", empty, 1'b1);
    store(32'h600, 32'h88);
    check_state("finished");

    // Sentinel into an empty FIFO.
    do_reset();
    store(DONE, 32'h0);
    check("empty_sent_done0", done, 1'b0);
    idle(1);
    check("empty_sent_done1", done, 1'b1);
    check_state("empty_sent");

    // Reset mid-operation with 5 entries and overflow set.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) store(32'hC00 + 32'(4 * i), 32'(400 + i));
    out_ready = 1'b1;
    idle(11);
    out_ready = 1'b0;
    check("mid_count", count, 5'd5);
    check("mid_overflow", overflow, 1'b1);
    do_reset();
    check_state("mid_reset");
    check("mid_reset_head", {out_addr, out_data}, 64'd0);
    out_ready = 1'b1;
    store(32'h400, 32'h55);
    check("mid_after_head", {out_addr, out_data}, {32'h400, 32'h55});
    idle(2);
    check_state("mid_after");
    check("mid_sb_left", sb.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
